input_capture: RTL and testbench

Upstream input stage for the control unit: synchronises and debounces the raw load pushbutton, latches the switch word on a clean press, and hands it over with a one-cycle `inputdata_ready` pulse. It is armed only while the control unit holds `loaddata` high. A press that arrives while it is not armed is dropped and flagged. It sits between the board I/O pins and the `controlunit`/datapath pair.

---
 rtl/input_capture_pkg.sv | 12 +
 rtl/debouncer.sv | 64 ++++++
 rtl/input_capture.sv | 81 ++++++++
 tb/tb_input_capture.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_capture_pkg.sv
// Shared types and default constants for the input capture stage.
package input_capture_pkg;

  localparam int DATA_WIDTH_DEF      = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic {
    WAIT_PRESS   = 1'b0,
    WAIT_RELEASE = 1'b1
  } capture_state_t;

endpackage

// File: rtl/debouncer.sv
// Two-flop button synchroniser plus optional debounce counter (INPUT_CAPTURE_DEBOUNCE_EN).
// dout follows din after 2 sync edges, plus CYCLES edges when debouncing; no backpressure.
module debouncer
  import input_capture_pkg::*;
#(
  parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

`ifdef INPUT_CAPTURE_DEBOUNCE_EN
  localparam int CW = $clog2(CYCLES + 1);

  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q,    cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CYCLES - 1)) begin
      // Disagreement has persisted long enough: accept the new level.
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;
`else
  logic unused_cycles;
  assign unused_cycles = (CYCLES > 0);
  assign dout          = s2_q;
`endif

endmodule

// File: rtl/input_capture.sv
// Syncs/debounces the load button and latches the switch word on a clean armed press.
// Pulse one edge after the debounced level rises (see debouncer, INPUT_CAPTURE_DEBOUNCE_EN); no backpressure.
module input_capture
  import input_capture_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_load,
  input  logic [DATA_WIDTH-1:0] sw_data,
  input  logic                  loaddata,
  output logic                  inputdata_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  dropped
);

  logic                  stable;
  logic [DATA_WIDTH-1:0] sw_s1_q, sw_s2_q;
  capture_state_t        state_q, state_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  dropped_q, dropped_d;

  debouncer #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .reset(reset),
    .din  (btn_load),
    .dout (stable)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      state_q   <= WAIT_PRESS;
      ready_q   <= 1'b0;
      data_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      sw_s1_q   <= sw_data;
      sw_s2_q   <= sw_s1_q;
      state_q   <= state_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_PRESS:   if (stable)  state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!stable) state_d = WAIT_PRESS;
      default:      state_d = WAIT_PRESS;
    endcase
  end

  // loaddata only matters on the edge that qualifies a press.
  always_comb begin
    ready_d   = 1'b0;
    data_d    = data_q;
    dropped_d = dropped_q;
    if (state_q == WAIT_PRESS && stable) begin
      if (loaddata) begin
        ready_d = 1'b1;
        data_d  = sw_s2_q;
      end else begin
        dropped_d = 1'b1;
      end
    end
  end

  assign inputdata_ready = ready_q;
  assign data_out        = data_q;
  assign dropped         = dropped_q;

endmodule

// File: tb/tb_input_capture.sv
// Self-checking bench for input_capture; window-based reference model, follows INPUT_CAPTURE_DEBOUNCE_EN.
module tb_input_capture;

  localparam int DW = 8;
  localparam int DC = 4;
`ifdef INPUT_CAPTURE_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = DC + 3;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_load;
  logic [DW-1:0] sw_data;
  logic          loaddata;
  logic          inputdata_ready;
  logic [DW-1:0] data_out;
  logic          dropped;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_capture #(
    .DATA_WIDTH     (DW),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_load       (btn_load),
    .sw_data        (sw_data),
    .loaddata       (loaddata),
    .inputdata_ready(inputdata_ready),
    .data_out       (data_out),
    .dropped        (dropped)
  );

  // Reference model: bh[0] = button sampled last edge, bh[k] = k edges earlier.
  // A level is accepted once the last DC synchronised samples all disagree with it.
  bit          bh [0:DC+1];
  bit [DW-1:0] swh [0:1];
  bit          m_stable   = 1'b0;
  bit          m_waitrel  = 1'b0;
  bit          exp_ready  = 1'b0;
  bit [DW-1:0] exp_data   = '0;
  bit          exp_dropped = 1'b0;

  always @(posedge clk) begin
    bit stab_pre;
    bit all_diff;
    if (reset) begin
      for (int k = 0; k <= DC + 1; k++) bh[k] = 1'b0;
      swh[0] = '0; swh[1] = '0;
      m_stable = 1'b0; m_waitrel = 1'b0;
      exp_ready = 1'b0; exp_data = '0; exp_dropped = 1'b0;
    end else begin
      stab_pre  = DEB ? m_stable : bh[1];
      exp_ready = 1'b0;
      if (!m_waitrel) begin
        if (stab_pre) begin
          if (loaddata) begin
            exp_ready = 1'b1;
            exp_data  = swh[1];
          end else begin
            exp_dropped = 1'b1;
          end
          m_waitrel = 1'b1;
        end
      end else if (!stab_pre) begin
        m_waitrel = 1'b0;
      end
      if (DEB) begin
        all_diff = 1'b1;
        for (int m = 1; m <= DC; m++) if (bh[m] == m_stable) all_diff = 1'b0;
        if (all_diff) m_stable = !m_stable;
      end
      for (int k = DC + 1; k >= 1; k--) bh[k] = bh[k-1];
      bh[0]  = btn_load;
      swh[1] = swh[0];
      swh[0] = sw_data;
    end
  end

  // Called on a negedge: apply inputs, advance one full cycle to the next negedge.
  task automatic drive(input bit b, input logic [DW-1:0] s, input bit l, input bit r);
    btn_load = b;
    sw_data  = s;
    loaddata = l;
    reset    = r;
    @(negedge clk);
  endtask

  task automatic test_reset();
    btn_load = 1'b0; sw_data = '0; loaddata = 1'b0; reset = 1'b1;
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (inputdata_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", inputdata_ready);
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h want 00", data_out);
    end
    checks++;
    if (dropped !== 1'b0) begin
      errors++; $display("FAIL reset_dropped: got %b want 0", dropped);
    end
  endtask

  task automatic test_basic_capture();
    int pulses = 0;
    int pulse_edge = -1;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'hA5, 1'b1, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      drive(i <= 10, 8'hA5, 1'b1, 1'b0);
      checks++;
      if ({inputdata_ready, data_out, dropped} !== {exp_ready, exp_data, exp_dropped}) begin
        errors++;
        $display("FAIL basic_cyc%0d: got rdy=%b dat=%h drp=%b want rdy=%b dat=%h drp=%b",
                 i, inputdata_ready, data_out, dropped, exp_ready, exp_data, exp_dropped);
      end
      if (inputdata_ready === 1'b1) begin
        pulses++;
        pulse_edge = i;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL basic_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (pulse_edge != LAT) begin
      errors++; $display("FAIL basic_latency: got edge %0d want %0d", pulse_edge, LAT);
    end
    checks++;
    if (data_out !== 8'hA5 || dropped !== 1'b0) begin
      errors++; $display("FAIL basic_data: got %h/%b want a5/0", data_out, dropped);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    logic [DW-1:0] want = DEB ? 8'hA5 : 8'h5A;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h5A, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      drive(i <= 3, 8'h5A, 1'b1, 1'b0);
      checks++;
      if ({inputdata_ready, data_out, dropped} !== {exp_ready, exp_data, exp_dropped}) begin
        errors++;
        $display("FAIL glitch_cyc%0d: got rdy=%b dat=%h drp=%b want rdy=%b dat=%h drp=%b",
                 i, inputdata_ready, data_out, dropped, exp_ready, exp_data, exp_dropped);
      end
      if (inputdata_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != (DEB ? 0 : 1) || data_out !== want) begin
      errors++;
      $display("FAIL glitch_result: got pulses=%0d dat=%h want pulses=%0d dat=%h",
               pulses, data_out, DEB ? 0 : 1, want);
    end
  endtask

  task automatic test_not_armed();
    int pulses = 0;
    logic [DW-1:0] want = DEB ? 8'hA5 : 8'h5A;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h3C, 1'b0, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      drive(i <= 10, 8'h3C, 1'b0, 1'b0);
      checks++;
      if ({inputdata_ready, data_out, dropped} !== {exp_ready, exp_data, exp_dropped}) begin
        errors++;
        $display("FAIL notarmed_cyc%0d: got rdy=%b dat=%h drp=%b want rdy=%b dat=%h drp=%b",
                 i, inputdata_ready, data_out, dropped, exp_ready, exp_data, exp_dropped);
      end
      if (inputdata_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || data_out !== want || dropped !== 1'b1) begin
      errors++;
      $display("FAIL notarmed_result: got pulses=%0d dat=%h drp=%b want 0/%h/1",
               pulses, data_out, dropped, want);
    end
  endtask

  task automatic test_hold_repress();
    int pulses = 0;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'hC3, 1'b1, 1'b0);
    for (int i = 1; i <= 72; i++) begin
      // 40 held, 10 released (word changes), 10 held, 12 released
      bit b = (i <= 40) || (i > 50 && i <= 60);
      drive(b, (i <= 40) ? 8'hC3 : 8'h0F, 1'b1, 1'b0);
      checks++;
      if ({inputdata_ready, data_out, dropped} !== {exp_ready, exp_data, exp_dropped}) begin
        errors++;
        $display("FAIL hold_cyc%0d: got rdy=%b dat=%h drp=%b want rdy=%b dat=%h drp=%b",
                 i, inputdata_ready, data_out, dropped, exp_ready, exp_data, exp_dropped);
      end
      if (inputdata_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2 || data_out !== 8'h0F || dropped !== 1'b1) begin
      errors++;
      $display("FAIL hold_result: got pulses=%0d dat=%h drp=%b want 2/0f/1",
               pulses, data_out, dropped);
    end
  endtask

  task automatic test_reset_mid_press();
    int pulses = 0;
    int pulse_edge = -1;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h99, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'h99, 1'b1, 1'b0);
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    checks++;
    if ({inputdata_ready, data_out, dropped} !== {1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midreset_clear: got rdy=%b dat=%h drp=%b want 0/00/0",
               inputdata_ready, data_out, dropped);
    end
    for (int k = 1; k <= 24; k++) begin
      drive(k <= 12, 8'h99, 1'b1, 1'b0);
      checks++;
      if ({inputdata_ready, data_out, dropped} !== {exp_ready, exp_data, exp_dropped}) begin
        errors++;
        $display("FAIL midreset_cyc%0d: got rdy=%b dat=%h drp=%b want rdy=%b dat=%h drp=%b",
                 k, inputdata_ready, data_out, dropped, exp_ready, exp_data, exp_dropped);
      end
      if (inputdata_ready === 1'b1) begin
        pulses++;
        pulse_edge = k;
      end
    end
    checks++;
    if (pulses != 1 || pulse_edge != LAT || data_out !== 8'h99) begin
      errors++;
      $display("FAIL midreset_result: got pulses=%0d edge=%0d dat=%h want 1/%0d/99",
               pulses, pulse_edge, data_out, LAT);
    end
  endtask

  task automatic test_random();
    bit            b = 1'b0;
    int            run = 0;
    logic [DW-1:0] s = 8'h00;
    for (int i = 1; i <= 600; i++) begin
      if (run == 0) begin
        b   = !b;
        run = $urandom_range(1, 10);
      end
      run--;
      if ($urandom_range(0, 7) == 0) s = DW'($urandom);
      drive(b, s, $urandom_range(0, 3) != 0, $urandom_range(0, 150) == 0);
      checks++;
      if ({inputdata_ready, data_out, dropped} !== {exp_ready, exp_data, exp_dropped}) begin
        errors++;
        $display("FAIL random_cyc%0d: got rdy=%b dat=%h drp=%b want rdy=%b dat=%h drp=%b",
                 i, inputdata_ready, data_out, dropped, exp_ready, exp_data, exp_dropped);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_glitch();
    test_not_armed();
    test_hold_repress();
    test_reset_mid_press();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
